// File: rtl/game_pkg.sv
// Shared definitions for the rock scheduler: state encoding, game constants
// and a popcount helper used to score multi-slot shot pulses.
package game_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HIT  = 2'd2,
    ST_OVER = 2'd3
  } game_state_e;

  localparam logic [1:0]  LIVES_INIT = 2'd3;
  localparam logic [2:0]  MOVE_BASE  = 3'd4;
  localparam logic [1:0]  MAX_LEVEL  = 2'd3;
  localparam logic [13:0] SCORE_MAX  = 14'd16383;

  function automatic logic [5:0] popcount32(input logic [31:0] v);
    logic [5:0] c;
    c = 6'd0;
    for (int i = 0; i < 32; i++) begin
      c = c + {5'd0, v[i]};
    end
    return c;
  endfunction

endpackage

// File: rtl/move_divider.sv
// Frame-tick divider producing the rock move strobe; the interval is sampled
// only on restart or reload, so a level change waits for the next period.
module move_divider
  import game_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       frame_tick_i,
  input  logic [2:0] interval_i,
  input  logic       restart_i,
  output logic       strobe_o
);

  logic [2:0] cnt_q, cnt_d;
  logic [2:0] ivl_q, ivl_d;

  // Next count, latched interval and strobe; a tick during restart counts as the first.
  always_comb begin
    cnt_d    = cnt_q;
    ivl_d    = ivl_q;
    strobe_o = 1'b0;
    if (restart_i) begin
      cnt_d = frame_tick_i ? 3'd1 : 3'd0;
      ivl_d = interval_i;
    end else if (frame_tick_i) begin
      if ((cnt_q + 3'd1) == ivl_q) begin
        strobe_o = 1'b1;
        cnt_d    = 3'd0;
        ivl_d    = interval_i;
      end else begin
        cnt_d = cnt_q + 3'd1;
      end
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Divider state register.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= 3'd0;
      ivl_q <= MOVE_BASE;
    end else begin
      cnt_q <= cnt_d;
      ivl_q <= ivl_d;
    end
  end

endmodule

// File: rtl/rock_scheduler.sv
// Game sequencer for the rock movers: spawns slots, paces their movement by
// level, tracks score/lives and handles the post-collision pause.
module rock_scheduler
  import game_pkg::*;
#(
  parameter int NROCKS     = 4,
  parameter int SPAWN_GAP  = 60,
  parameter int LEVEL_STEP = 16,
  parameter int HIT_FRAMES = 120
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              frame_tick,
  input  logic              start,
  input  logic              planehit,
  input  logic [NROCKS-1:0] shot,
  output logic [NROCKS-1:0] rock_move,
  output logic [NROCKS-1:0] rock_rst,
  output logic [1:0]        level,
  output logic [13:0]       score,
  output logic [1:0]        lives,
  output logic [1:0]        game_state
);

  localparam int IW = $clog2(NROCKS + 1);
  localparam int SW = $clog2(SPAWN_GAP + 1);
  localparam int HW = $clog2(HIT_FRAMES + 1);
  localparam int AW = $clog2(LEVEL_STEP + 1);

  game_state_e       state_q, state_d;
  logic [13:0]       score_q, score_d;
  logic [1:0]        lives_q, lives_d;
  logic [1:0]        level_q, level_d;
  logic [AW-1:0]     acc_q, acc_d;
  logic [NROCKS-1:0] active_q, active_d;
  logic [IW-1:0]     spawn_idx_q, spawn_idx_d;
  logic [SW-1:0]     spawn_cnt_q, spawn_cnt_d;
  logic [HW-1:0]     hit_cnt_q, hit_cnt_d;
  logic [NROCKS-1:0] rock_move_q, rock_rst_q;

  logic [5:0]        pc_s;
  logic [14:0]       score_sum_s;
  logic [7:0]        acc_sum_s;
  logic [2:0]        interval_s;
  logic              div_restart_s, div_tick_s, div_strobe_s;
  logic [IW-1:0]     sp_idx_s;
  logic [SW-1:0]     sp_cnt_s;
  logic [NROCKS-1:0] sp_act_s;
  logic              sp_tick_s;

  assign pc_s        = popcount32(32'(shot));
  assign score_sum_s = {1'b0, score_q} + {9'd0, pc_s};
  assign acc_sum_s   = 8'(acc_q) + {2'd0, pc_s};
  // Leaving IDLE always starts at level 0, whatever the previous game reached.
  assign interval_s  = (state_q == ST_IDLE) ? MOVE_BASE : (MOVE_BASE - {1'b0, level_q});

  move_divider u_move_divider (
    .clk_i        (clk),
    .rst_i        (rst),
    .frame_tick_i (div_tick_s),
    .interval_i   (interval_s),
    .restart_i    (div_restart_s),
    .strobe_o     (div_strobe_s)
  );

  // Next-state logic; a tick on a transition cycle is applied to the entered state.
  always_comb begin
    state_d       = state_q;
    score_d       = score_q;
    lives_d       = lives_q;
    level_d       = level_q;
    acc_d         = acc_q;
    hit_cnt_d     = hit_cnt_q;
    sp_idx_s      = spawn_idx_q;
    sp_cnt_s      = spawn_cnt_q;
    sp_act_s      = active_q;
    sp_tick_s     = 1'b0;
    div_restart_s = 1'b1;
    div_tick_s    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d    = ST_RUN;
          score_d    = 14'd0;
          lives_d    = LIVES_INIT;
          level_d    = 2'd0;
          acc_d      = {AW{1'b0}};
          hit_cnt_d  = {HW{1'b0}};
          sp_idx_s   = {IW{1'b0}};
          sp_cnt_s   = {SW{1'b0}};
          sp_act_s   = {NROCKS{1'b0}};
          sp_tick_s  = frame_tick;
          div_tick_s = frame_tick;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RUN: begin
        score_d = (score_sum_s > {1'b0, SCORE_MAX}) ? SCORE_MAX : score_sum_s[13:0];
        if (acc_sum_s >= 8'(LEVEL_STEP)) begin
          acc_d   = AW'(acc_sum_s - 8'(LEVEL_STEP));
          level_d = (level_q == MAX_LEVEL) ? MAX_LEVEL : (level_q + 2'd1);
        end else begin
          acc_d = AW'(acc_sum_s);
        end
        if (planehit) begin
          state_d   = ST_HIT;
          lives_d   = lives_q - 2'd1;
          sp_act_s  = {NROCKS{1'b0}};
          hit_cnt_d = frame_tick ? HW'(1) : HW'(0);
        end else begin
          div_restart_s = 1'b0;
          div_tick_s    = frame_tick;
          sp_tick_s     = frame_tick;
        end
      end
      ST_HIT: begin
        if (frame_tick) begin
          if (hit_cnt_q == HW'(HIT_FRAMES - 1)) begin
            hit_cnt_d = {HW{1'b0}};
            state_d   = (lives_q != 2'd0) ? ST_RUN : ST_OVER;
            sp_idx_s  = {IW{1'b0}};
            sp_cnt_s  = {SW{1'b0}};
          end else begin
            hit_cnt_d = hit_cnt_q + HW'(1);
          end
        end else begin
          hit_cnt_d = hit_cnt_q;
        end
      end
      ST_OVER: state_d = start ? ST_IDLE : ST_OVER;
      default: state_d = ST_IDLE;
    endcase

    active_d    = sp_act_s;
    spawn_idx_d = sp_idx_s;
    spawn_cnt_d = sp_cnt_s;
    if (sp_tick_s && (sp_idx_s < IW'(NROCKS))) begin
      if ((sp_idx_s == {IW{1'b0}}) || (sp_cnt_s == SW'(SPAWN_GAP - 1))) begin
        for (int i = 0; i < NROCKS; i++) begin
          active_d[i] = sp_act_s[i] | (sp_idx_s == IW'(i));
        end
        spawn_idx_d = sp_idx_s + IW'(1);
        spawn_cnt_d = {SW{1'b0}};
      end else begin
        spawn_cnt_d = sp_cnt_s + SW'(1);
      end
    end else begin
      spawn_cnt_d = sp_cnt_s;
    end
  end

  // State, counters and registered per-slot outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      score_q     <= 14'd0;
      lives_q     <= LIVES_INIT;
      level_q     <= 2'd0;
      acc_q       <= {AW{1'b0}};
      active_q    <= {NROCKS{1'b0}};
      spawn_idx_q <= {IW{1'b0}};
      spawn_cnt_q <= {SW{1'b0}};
      hit_cnt_q   <= {HW{1'b0}};
      rock_move_q <= {NROCKS{1'b0}};
      rock_rst_q  <= {NROCKS{1'b1}};
    end else begin
      state_q     <= state_d;
      score_q     <= score_d;
      lives_q     <= lives_d;
      level_q     <= level_d;
      acc_q       <= acc_d;
      active_q    <= active_d;
      spawn_idx_q <= spawn_idx_d;
      spawn_cnt_q <= spawn_cnt_d;
      hit_cnt_q   <= hit_cnt_d;
      rock_move_q <= div_strobe_s ? active_q : {NROCKS{1'b0}};
      rock_rst_q  <= (state_d == ST_RUN) ? ~active_d : {NROCKS{1'b1}};
    end
  end

  assign rock_move  = rock_move_q;
  assign rock_rst   = rock_rst_q;
  assign level      = level_q;
  assign score      = score_q;
  assign lives      = lives_q;
  assign game_state = state_q;

endmodule

// File: tb/tb_rock_scheduler.sv
// Self-checking bench for rock_scheduler: directed scenarios plus random
// traffic, all compared cycle by cycle against an event-level game model.
module tb_rock_scheduler;

  localparam int NR   = 4;
  localparam int GAP  = 60;
  localparam int STEP = 16;
  localparam int HF   = 120;

  logic          clk = 1'b0;
  logic          rst, frame_tick, start, planehit;
  logic [NR-1:0] shot, rock_move, rock_rst;
  logic [1:0]    level, lives, game_state;
  logic [13:0]   score;

  int tests_run    = 0;
  int tests_failed = 0;

  // Model: game state as plain counts (ticks since RUN entry, shots this game).
  int         m_state, m_score, m_lives, m_level, m_shots;
  int         m_run_ticks, m_hit, m_div, m_ivl;
  logic [3:0] m_move, m_rstv;

  rock_scheduler #(
    .NROCKS(NR), .SPAWN_GAP(GAP), .LEVEL_STEP(STEP), .HIT_FRAMES(HF)
  ) dut (
    .clk(clk), .rst(rst), .frame_tick(frame_tick), .start(start),
    .planehit(planehit), .shot(shot), .rock_move(rock_move),
    .rock_rst(rock_rst), .level(level), .score(score), .lives(lives),
    .game_state(game_state)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // Slots released so far: one at the first tick, then one per GAP ticks.
  function automatic logic [3:0] mask_of(input int rt);
    int n;
    n = (rt < 1) ? 0 : 1 + (rt - 1) / GAP;
    if (n > NR) n = NR;
    return 4'((1 << n) - 1);
  endfunction

  task automatic model_step(input logic s, input logic t, input logic p,
                            input logic [3:0] sh, input logic r);
    logic [3:0] pre;
    int old_lv;
    m_move = 4'd0;
    if (r) begin
      m_state = 0; m_score = 0; m_lives = 3; m_level = 0; m_shots = 0;
      m_run_ticks = 0; m_hit = 0; m_div = 0; m_ivl = 4;
    end else begin
      case (m_state)
        0: if (s) begin
          m_state = 1; m_score = 0; m_lives = 3; m_level = 0; m_shots = 0;
          m_run_ticks = t ? 1 : 0; m_div = t ? 1 : 0; m_ivl = 4;
        end
        1: begin
          pre = mask_of(m_run_ticks);
          old_lv = m_level;
          m_shots += $countones(sh);
          m_score = (m_score + $countones(sh) > 16383) ? 16383 : m_score + $countones(sh);
          m_level = (m_shots / STEP > 3) ? 3 : m_shots / STEP;
          if (p) begin
            m_lives--; m_state = 2; m_hit = t ? 1 : 0;
          end else if (t) begin
            m_run_ticks++;
            m_div++;
            if (m_div == m_ivl) begin
              m_move = pre; m_div = 0; m_ivl = 4 - old_lv;
            end
          end
        end
        2: if (t) begin
          m_hit++;
          if (m_hit == HF) begin
            m_state = (m_lives > 0) ? 1 : 3;
            m_run_ticks = 0; m_div = 0; m_ivl = 4 - m_level; m_hit = 0;
          end
        end
        default: if (s) m_state = 0;
      endcase
    end
    m_rstv = (m_state == 1) ? ~mask_of(m_run_ticks) : 4'hF;
  endtask

  task automatic step(input logic s, input logic t, input logic p,
                      input logic [3:0] sh, input logic r);
    start = s; frame_tick = t; planehit = p; shot = sh; rst = r;
    model_step(s, t, p, sh, r);
    @(posedge clk);
    @(negedge clk);
    chk("state", 32'(game_state), 32'(m_state));
    chk("score", 32'(score), 32'(m_score));
    chk("lives", 32'(lives), 32'(m_lives));
    chk("level", 32'(level), 32'(m_level));
    chk("rock_move", 32'(rock_move), 32'(m_move));
    chk("rock_rst", 32'(rock_rst), 32'(m_rstv));
  endtask

  task automatic ticks(input int n);
    for (int k = 0; k < n; k++) begin
      step(1'b0, 1'b1, 1'b0, 4'd0, 1'b0);
      step(1'b0, 1'b0, 1'b0, 4'd0, 1'b0);
    end
  endtask

  initial begin
    int rel_at [4];
    int mv0, mv3;
    logic [3:0] one_hot;
    logic s, t, p, r;
    logic [3:0] sh;

    rst = 1'b1; frame_tick = 1'b0; start = 1'b0; planehit = 1'b0; shot = 4'd0;
    @(negedge clk);
    step(1'b0, 1'b0, 1'b0, 4'd0, 1'b1);
    chk("reset_rock_rst", 32'(rock_rst), 32'hF);
    chk("reset_lives", 32'(lives), 32'd3);
    step(1'b0, 1'b0, 1'b0, 4'd0, 1'b0);

    // Spawn schedule and move cadence over 300 frames.
    step(1'b1, 1'b0, 1'b0, 4'd0, 1'b0);
    for (int i = 0; i < 4; i++) rel_at[i] = -1;
    mv0 = 0; mv3 = 0;
    for (int k = 1; k <= 300; k++) begin
      step(1'b0, 1'b1, 1'b0, 4'd0, 1'b0);
      for (int i = 0; i < 4; i++)
        if (rel_at[i] < 0 && rock_rst[i] == 1'b0) rel_at[i] = k;
      mv0 += int'(rock_move[0]);
      mv3 += int'(rock_move[3]);
      step(1'b0, 1'b0, 1'b0, 4'd0, 1'b0);
    end
    chk("release_slot0", rel_at[0], 32'd1);
    chk("release_slot1", rel_at[1], 32'd61);
    chk("release_slot2", rel_at[2], 32'd121);
    chk("release_slot3", rel_at[3], 32'd181);
    chk("moves_slot0", mv0, 32'd75);
    chk("moves_slot3", mv3, 32'd30);

    // Level progression and multi-bit shots.
    for (int k = 0; k < 16; k++) begin
      one_hot = 4'd1 << (k % 4);
      step(1'b0, 1'b0, 1'b0, one_hot, 1'b0);
    end
    chk("score_16", 32'(score), 32'd16);
    chk("level_1", 32'(level), 32'd1);
    ticks(12);
    for (int k = 0; k < 48; k++) step(1'b0, 1'b0, 1'b0, 4'b0100, 1'b0);
    chk("level_sat", 32'(level), 32'd3);
    step(1'b0, 1'b0, 1'b0, 4'b1011, 1'b0);
    chk("score_plus3", 32'(score), 32'd67);
    ticks(10);

    // Collision pause and re-spawn from slot 0.
    step(1'b0, 1'b0, 1'b1, 4'd0, 1'b0);
    chk("hit_lives", 32'(lives), 32'd2);
    chk("hit_state", 32'(game_state), 32'd2);
    ticks(119);
    chk("hit_still", 32'(game_state), 32'd2);
    chk("hit_rock_rst", 32'(rock_rst), 32'hF);
    ticks(1);
    chk("hit_back_run", 32'(game_state), 32'd1);
    ticks(1);
    chk("respawn_slot0", 32'(rock_rst), 32'hE);

    // Reset in the middle of a pause.
    step(1'b0, 1'b0, 1'b1, 4'd0, 1'b0);
    ticks(30);
    step(1'b0, 1'b0, 1'b0, 4'd0, 1'b1);
    chk("rst_state", 32'(game_state), 32'd0);
    chk("rst_score", 32'(score), 32'd0);
    chk("rst_lives", 32'(lives), 32'd3);
    chk("rst_level", 32'(level), 32'd0);
    chk("rst_rock_rst", 32'(rock_rst), 32'hF);

    // Three collisions end the game; two starts begin a fresh one.
    step(1'b1, 1'b0, 1'b0, 4'd0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 4'd0, 1'b0);
    for (int k = 0; k < 5; k++) step(1'b0, 1'b0, 1'b0, 4'b0010, 1'b0);
    for (int h = 0; h < 3; h++) begin
      ticks(3);
      step(1'b0, 1'b1, 1'b1, 4'd0, 1'b0);
      ticks(HF - 1);
    end
    chk("over_state", 32'(game_state), 32'd3);
    chk("over_score", 32'(score), 32'd5);
    step(1'b1, 1'b0, 1'b0, 4'd0, 1'b0);
    chk("over_to_idle", 32'(game_state), 32'd0);
    step(1'b0, 1'b0, 1'b0, 4'd0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 4'd0, 1'b0);
    chk("restart_score", 32'(score), 32'd0);
    chk("restart_lives", 32'(lives), 32'd3);

    // Score saturation.
    step(1'b0, 1'b0, 1'b0, 4'd0, 1'b0);
    for (int k = 0; k < 4100; k++) step(1'b0, 1'b0, 1'b0, 4'hF, 1'b0);
    chk("score_sat", 32'(score), 32'd16383);

    // Random traffic, including coincident ticks, hits, starts and resets.
    for (int k = 0; k < 15000; k++) begin
      t  = ($urandom_range(0, 2) == 0);
      s  = ($urandom_range(0, 15) == 0);
      p  = ($urandom_range(0, 299) == 0);
      r  = ($urandom_range(0, 2999) == 0);
      sh = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(0, 15)) : 4'd0;
      step(s, t, p, sh, r);
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
